// File: rtl/dma_peripheral_port_pkg.sv
// Shared types and constants for the DMA peripheral-port endpoint.
package dma_peripheral_port_pkg;

  localparam int BYTE_W     = 8;
  localparam int XFER_CNT_W = 16;

  // Value presented on the bus when a read hits an empty FIFO
  localparam logic [BYTE_W-1:0] DB_EMPTY_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    REQ     = 3'd2,
    XFER    = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } port_state_e;

  typedef enum logic {
    DIR_IO2MEM = 1'b0,
    DIR_MEM2IO = 1'b1
  } xfer_dir_e;

endpackage

// File: rtl/dma_peripheral_port_if.sv
// Controller-side DMA channel pins: request/acknowledge, I/O strobes, end-of-process and data bus.
interface dma_peripheral_port_if;
  import dma_peripheral_port_pkg::*;

  logic              dreq;
  logic              dack;
  logic              ior_n;
  logic              iow_n;
  logic              eop_n;
  logic [BYTE_W-1:0] db_in;
  logic [BYTE_W-1:0] db_out;
  logic              db_oe;

  modport slave (
    output dreq, db_out, db_oe,
    input  dack, ior_n, iow_n, eop_n, db_in
  );

  modport master (
    input  dreq, db_out, db_oe,
    output dack, ior_n, iow_n, eop_n, db_in
  );

endinterface

// File: rtl/dma_peripheral_port_fifo.sv
// Synchronous byte FIFO shared by both transfer directions.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module dma_byte_fifo
  import dma_peripheral_port_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [BYTE_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [BYTE_W-1:0]      o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dma_peripheral_port.sv
// Device end of one 8237-style DMA channel: request FSM, strobe edge detect,
// byte counter and error flag around a shared byte FIFO.
module dma_peripheral_port
  import dma_peripheral_port_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter bit DEMAND_MODE = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dma_peripheral_port_if.slave  bus,
  input  logic                  i_enable,
  input  logic                  i_xfer_dir,
  input  logic                  i_dev_wr_valid,
  input  logic [BYTE_W-1:0]     i_dev_wr_data,
  output logic                  o_dev_wr_ready,
  output logic                  o_dev_rd_valid,
  output logic [BYTE_W-1:0]     o_dev_rd_data,
  input  logic                  i_dev_rd_ready,
  output logic [XFER_CNT_W-1:0] o_xfer_count,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  port_state_e           r_state;
  port_state_e           w_state_nxt;
  xfer_dir_e             r_dir;
  xfer_dir_e             w_dir;
  logic                  r_ior_q;
  logic                  r_iow_q;
  logic                  r_dack_q;
  logic [BYTE_W-1:0]     r_db_lat;
  logic                  r_dreq;
  logic                  r_done;
  logic                  r_err;
  logic [XFER_CNT_W-1:0] r_xfer_count;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;
  logic [BYTE_W-1:0]     w_fifo_head;
  logic [BYTE_W-1:0]     w_fifo_din;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic                  w_dev_push;
  logic                  w_dev_pop;

  logic                  w_rd_strobe;
  logic                  w_wr_strobe;
  logic                  w_strobe;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_byte_done;
  logic                  w_bus_err;
  logic                  w_ready;
  logic                  w_arm;
  logic                  w_db_oe;

  // Direction follows the pin while idle and is frozen once armed
  assign w_dir = (r_state == IDLE) ? xfer_dir_e'(i_xfer_dir) : r_dir;

  assign w_rd_strobe = ~r_ior_q & bus.ior_n & r_dack_q & (w_dir == DIR_IO2MEM);
  assign w_wr_strobe = ~r_iow_q & bus.iow_n & r_dack_q & (w_dir == DIR_MEM2IO);
  assign w_strobe    = w_rd_strobe | w_wr_strobe;
  assign w_rd_ok     = w_rd_strobe & ~w_fifo_empty;
  assign w_wr_ok     = w_wr_strobe & ~w_fifo_full;
  assign w_byte_done = w_rd_ok | w_wr_ok;
  assign w_bus_err   = (w_rd_strobe & w_fifo_empty) | (w_wr_strobe & w_fifo_full);

  assign w_ready = (w_dir == DIR_IO2MEM) ? (w_fifo_count != '0)
                                         : (w_fifo_count <= CW'(FIFO_DEPTH - 1));

  assign w_dev_push  = i_dev_wr_valid & (w_dir == DIR_IO2MEM);
  assign w_dev_pop   = i_dev_rd_ready & o_dev_rd_valid;
  assign w_fifo_push = w_wr_ok | w_dev_push;
  assign w_fifo_pop  = w_rd_ok | w_dev_pop;
  assign w_fifo_din  = (w_dir == DIR_MEM2IO) ? r_db_lat : i_dev_wr_data;

  dma_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_fifo_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_enable) begin
          w_state_nxt = ARMED;
          w_arm       = 1'b1;
        end
      end
      ARMED: begin
        if (!i_enable)    w_state_nxt = IDLE;
        else if (w_ready) w_state_nxt = REQ;
      end
      REQ: begin
        if (!i_enable)     w_state_nxt = IDLE;
        else if (bus.dack) w_state_nxt = XFER;
      end
      XFER: begin
        // Demand mode judges readiness on the pre-commit level, so DREQ
        // falls one cycle after the byte that empties/fills the FIFO.
        if (w_strobe) begin
          if (!DEMAND_MODE)             w_state_nxt = RECOVER;
          else if (i_enable && w_ready) w_state_nxt = XFER;
          else                          w_state_nxt = ARMED;
        end else if (DEMAND_MODE && !w_ready) begin
          w_state_nxt = ARMED;
        end
      end
      RECOVER: begin
        if (!bus.dack) w_state_nxt = ARMED;
      end
      DONE: begin
        if (!i_enable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if ((r_state != IDLE) && (r_state != DONE) && !bus.eop_n && bus.dack)
      w_state_nxt = DONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_dir        <= DIR_IO2MEM;
      r_ior_q      <= 1'b1;
      r_iow_q      <= 1'b1;
      r_dack_q     <= 1'b0;
      r_db_lat     <= '0;
      r_dreq       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ior_q  <= bus.ior_n;
      r_iow_q  <= bus.iow_n;
      r_dack_q <= bus.dack;
      if (!bus.iow_n)        r_db_lat <= bus.db_in;
      if (r_state == IDLE)   r_dir    <= xfer_dir_e'(i_xfer_dir);
      r_dreq <= (w_state_nxt == REQ) || (w_state_nxt == XFER);
      r_done <= (w_state_nxt == DONE) && (r_state != DONE);
      if (w_arm) begin
        r_xfer_count <= '0;
        r_err        <= 1'b0;
      end else begin
        if (w_byte_done) r_xfer_count <= r_xfer_count + XFER_CNT_W'(1);
        if (w_bus_err)   r_err        <= 1'b1;
      end
    end
  end

  // Data bus is parked at zero whenever the controller is not reading us
  assign w_db_oe    = bus.dack & ~bus.ior_n & ~i_xfer_dir;
  assign bus.db_oe  = w_db_oe;
  assign bus.db_out = w_db_oe ? (w_fifo_empty ? DB_EMPTY_BYTE : w_fifo_head) : '0;
  assign bus.dreq   = r_dreq;

  assign o_dev_wr_ready = ~w_fifo_full & (w_dir == DIR_IO2MEM);
  assign o_dev_rd_valid = ~w_fifo_empty & (w_dir == DIR_MEM2IO);
  assign o_dev_rd_data  = w_fifo_head;
  assign o_xfer_count   = r_xfer_count;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_dma_peripheral_port.sv
// Directed bench: single-mode and demand-mode instances driven by a simple controller model.
module tb_dma_peripheral_port;
  import dma_peripheral_port_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  dma_peripheral_port_if bus ();
  dma_peripheral_port_if bus_d ();

  logic        enable, xfer_dir, dev_wr_valid, dev_rd_ready;
  logic [7:0]  dev_wr_data, dev_rd_data;
  logic        dev_wr_ready, dev_rd_valid, done, err;
  logic [15:0] xfer_count;

  logic        enable_d, dev_wr_valid_d;
  logic [7:0]  dev_wr_data_d, dev_rd_data_d;
  logic        dev_wr_ready_d, dev_rd_valid_d, done_d, err_d;
  logic [15:0] xfer_count_d;

  dma_peripheral_port #(.FIFO_DEPTH(8), .DEMAND_MODE(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .i_enable(enable), .i_xfer_dir(xfer_dir),
    .i_dev_wr_valid(dev_wr_valid), .i_dev_wr_data(dev_wr_data), .o_dev_wr_ready(dev_wr_ready),
    .o_dev_rd_valid(dev_rd_valid), .o_dev_rd_data(dev_rd_data), .i_dev_rd_ready(dev_rd_ready),
    .o_xfer_count(xfer_count), .o_done(done), .o_err(err)
  );

  dma_peripheral_port #(.FIFO_DEPTH(8), .DEMAND_MODE(1'b1)) dut_d (
    .i_clk(clk), .i_rst(rst), .bus(bus_d),
    .i_enable(enable_d), .i_xfer_dir(1'b0),
    .i_dev_wr_valid(dev_wr_valid_d), .i_dev_wr_data(dev_wr_data_d), .o_dev_wr_ready(dev_wr_ready_d),
    .o_dev_rd_valid(dev_rd_valid_d), .o_dev_rd_data(dev_rd_data_d), .i_dev_rd_ready(1'b0),
    .o_xfer_count(xfer_count_d), .o_done(done_d), .o_err(err_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dreq(input string tag);
    int n = 0;
    while (bus.dreq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_dreq_wait"}, 32'(bus.dreq), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    dev_wr_valid = 1'b1;
    dev_wr_data  = b;
    tick();
    dev_wr_valid = 1'b0;
  endtask

  // Single-mode read: DACK one cycle after DREQ, IOR_N low for two cycles
  task automatic read_single(input string tag, input logic [7:0] exp);
    wait_dreq(tag);
    tick();
    bus.dack  = 1'b1;
    bus.ior_n = 1'b0;
    #1;
    check({tag, "_oe"}, 32'(bus.db_oe), 32'd1);
    check({tag, "_db"}, 32'(bus.db_out), 32'(exp));
    tick();
    tick();
    bus.ior_n = 1'b1;
    tick();
    check({tag, "_dreq_drop"}, 32'(bus.dreq), 32'd0);
    tick();
    check({tag, "_dreq_hold_low"}, 32'(bus.dreq), 32'd0);
    bus.dack = 1'b0;
  endtask

  initial begin
    bus.dack = 1'b0; bus.ior_n = 1'b1; bus.iow_n = 1'b1; bus.eop_n = 1'b1; bus.db_in = 8'h00;
    bus_d.dack = 1'b0; bus_d.ior_n = 1'b1; bus_d.iow_n = 1'b1; bus_d.eop_n = 1'b1; bus_d.db_in = 8'h00;
    enable = 1'b0; xfer_dir = 1'b0; dev_wr_valid = 1'b0; dev_wr_data = 8'h00; dev_rd_ready = 1'b0;
    enable_d = 1'b0; dev_wr_valid_d = 1'b0; dev_wr_data_d = 8'h00;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_dreq", 32'(bus.dreq), 32'd0);
    check("rst_oe", 32'(bus.db_oe), 32'd0);
    check("rst_db", 32'(bus.db_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));

    // Demand mode: DREQ held through three strobes
    for (int i = 0; i < 3; i++) begin
      dev_wr_valid_d = 1'b1;
      dev_wr_data_d  = 8'hA1 + 8'(i);
      tick();
    end
    dev_wr_valid_d = 1'b0;
    enable_d = 1'b1;
    begin
      int n = 0;
      while (bus_d.dreq !== 1'b1 && n < 20) begin tick(); n++; end
    end
    check("dem_dreq_wait", 32'(bus_d.dreq), 32'd1);
    tick();
    bus_d.dack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_d.ior_n = 1'b0;
      #1;
      check("dem_db", 32'(bus_d.db_out), 32'(8'hA1 + 8'(i)));
      tick();
      tick();
      bus_d.ior_n = 1'b1;
      tick();
      check("dem_dreq_held", 32'(bus_d.dreq), 32'd1);
    end
    check("dem_fifo_empty", 32'(dut_d.w_fifo_empty), 32'd1);
    check("dem_count", 32'(xfer_count_d), 32'd3);
    tick();
    check("dem_dreq_drop", 32'(bus_d.dreq), 32'd0);
    bus_d.dack = 1'b0;

    // dir0, two bytes, single mode
    push_byte(8'hA5);
    push_byte(8'h3C);
    check("t1_wr_ready", 32'(dev_wr_ready), 32'd1);
    enable = 1'b1;
    read_single("t1_b0", 8'hA5);
    read_single("t1_b1", 8'h3C);
    tick(); tick();
    check("t1_count", 32'(xfer_count), 32'd2);
    check("t1_empty", 32'(dut.w_fifo_empty), 32'd1);
    check("t1_dreq_low", 32'(bus.dreq), 32'd0);

    // Re-arm, three bytes in single mode
    enable = 1'b0;
    tick(); tick();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    enable = 1'b1;
    read_single("t2_b0", 8'h01);
    read_single("t2_b1", 8'h02);
    read_single("t2_b2", 8'h03);
    tick(); tick();
    check("t2_count", 32'(xfer_count), 32'd3);

    // Forced read on empty FIFO
    bus.dack  = 1'b1;
    bus.ior_n = 1'b0;
    #1;
    check("t5_oe", 32'(bus.db_oe), 32'd1);
    check("t5_db_ff", 32'(bus.db_out), 32'hFF);
    tick(); tick();
    bus.ior_n = 1'b1;
    tick();
    check("t5_err", 32'(err), 32'd1);
    check("t5_count_kept", 32'(xfer_count), 32'd3);
    bus.dack = 1'b0;
    tick();

    // dir1 writes, EOP on the second byte
    enable = 1'b0;
    tick(); tick();
    xfer_dir = 1'b1;
    enable = 1'b1;
    tick();
    check("t4_err_clr", 32'(err), 32'd0);
    check("t4_count_clr", 32'(xfer_count), 32'd0);
    check("t4_wr_ready", 32'(dev_wr_ready), 32'd0);
    wait_dreq("t4_b0");
    tick();
    bus.dack = 1'b1; bus.db_in = 8'h11; bus.iow_n = 1'b0;
    tick(); tick();
    bus.iow_n = 1'b1;
    tick();
    check("t4_b0_dreq_drop", 32'(bus.dreq), 32'd0);
    check("t4_b0_rd_valid", 32'(dev_rd_valid), 32'd1);
    check("t4_b0_rd_data", 32'(dev_rd_data), 32'h11);
    bus.dack = 1'b0;
    wait_dreq("t4_b1");
    tick();
    bus.dack = 1'b1; bus.db_in = 8'h22; bus.iow_n = 1'b0;
    tick(); tick();
    bus.db_in = 8'h99;
    bus.iow_n = 1'b1;
    bus.eop_n = 1'b0;
    tick();
    check("t4_done_pulse", 32'(done), 32'd1);
    check("t4_count", 32'(xfer_count), 32'd2);
    check("t4_dreq_done", 32'(bus.dreq), 32'd0);
    bus.eop_n = 1'b1;
    bus.dack  = 1'b0;
    tick();
    check("t4_done_one_cycle", 32'(done), 32'd0);
    dev_rd_ready = 1'b1;
    check("t4_pop0", 32'(dev_rd_data), 32'h11);
    tick();
    check("t4_pop1", 32'(dev_rd_data), 32'h22);
    tick();
    dev_rd_ready = 1'b0;
    check("t4_drained", 32'(dev_rd_valid), 32'd0);
    tick(); tick();
    check("t4_dreq_stays_low", 32'(bus.dreq), 32'd0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_dreq("t4_rearm");

    // Reset in the middle of a transfer
    enable = 1'b0;
    xfer_dir = 1'b0;
    tick(); tick();
    push_byte(8'h0A);
    push_byte(8'h0B);
    push_byte(8'h0C);
    push_byte(8'h0D);
    enable = 1'b1;
    wait_dreq("t6");
    tick();
    bus.dack = 1'b1; bus.ior_n = 1'b0;
    tick();
    check("t6_in_xfer", 32'(dut.r_state), 32'(XFER));
    rst = 1'b1;
    tick();
    check("t6_dreq", 32'(bus.dreq), 32'd0);
    check("t6_empty", 32'(dut.w_fifo_empty), 32'd1);
    check("t6_count", 32'(xfer_count), 32'd0);
    check("t6_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    bus.dack = 1'b0; bus.ior_n = 1'b1; enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
